bus_master_port: RTL and testbench
==================================

BUS_MASTER_PORT -- requirements
Module: bus_master_port

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, SHALL set the device address width and the number of serial address bits.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the data word width and the number of serial data bits.
REQ-003 Parameter ACK_TIMEOUT, default 16, SHALL set the maximum number of cycles spent waiting for slave acknowledge.
REQ-004 One clock, clk; reset is synchronous and active-low, rstn.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rstn  in  1  synchronous active-low reset.
REQ-007 dvalid  in  1  device request strobe.
REQ-008 daddr  in  ADDR_WIDTH  target address, sampled on accept.
REQ-009 dwdata  in  DATA_WIDTH  write data, sampled on accept.
REQ-010 dmode  in  1  0 = read, 1 = write, sampled on accept.
REQ-011 dready  out  1  port idle, request accepted when dvalid & dready.
REQ-012 drdata  out  DATA_WIDTH  last completed read data.
REQ-013 derror  out  1  last transaction aborted; valid while dready = 1.
REQ-014 mbreq  out  1  bus request to arbiter.
REQ-015 mbgrant  in  1  bus grant from arbiter.
REQ-016 m_mode  out  1  latched dmode, driven to the bus.
REQ-017 m_addr, m_addr_valid  out  1, 1  serial address bit and qualifier.
REQ-018 m_wdata, m_wdata_valid  out  1, 1  serial write bit and qualifier.
REQ-019 m_rdata, m_rdata_valid  in  1, 1  serial read bit and qualifier from slave.
REQ-020 m_ack  in  1  slave address acknowledge.

Function
REQ-021 FSM states SHALL be IDLE, REQ, ADDR, ACK, WDATA, RDATA, DONE.
REQ-022 IDLE: dready = 1; on dvalid the port SHALL latch daddr/dwdata/dmode, clear derror, and go to REQ; dvalid while dready = 0 SHALL be ignored.
REQ-023 REQ: mbreq = 1; mbgrant sampled high SHALL move to ADDR next cycle; there is no timeout.
REQ-024 mbreq SHALL stay 1 from REQ through the last cycle of WDATA/RDATA and be 0 in IDLE and DONE.
REQ-025 ADDR: exactly ADDR_WIDTH consecutive cycles, LSB first, m_addr_valid = 1, then ACK.
REQ-026 ACK: m_ack high SHALL go to WDATA (write) or RDATA (read); after ACK_TIMEOUT cycles without m_ack, set derror = 1 and go to DONE.
REQ-027 WDATA: exactly DATA_WIDTH consecutive cycles, LSB first, m_wdata_valid = 1, then DONE.
REQ-028 RDATA: shift m_rdata in LSB first only on cycles with m_rdata_valid = 1; after DATA_WIDTH valid bits go to DONE; gaps are allowed.
REQ-029 drdata SHALL update only on entry to DONE after a successful read; writes and aborts leave it unchanged.
REQ-030 mbgrant low during ADDR, ACK, WDATA or RDATA SHALL abort: set derror = 1, drop mbreq, go to DONE.
REQ-031 DONE lasts one cycle, then IDLE.
REQ-032 m_mode SHALL be held constant from REQ through DONE.
REQ-033 Bit counters SHALL be sized by clog2 of the widths and SHALL not wrap within a phase.
REQ-034 m_addr_valid and m_wdata_valid SHALL never be high in the same cycle.

Reset
REQ-035 When rstn = 0, next state SHALL be IDLE, dready = 1 after reset, and mbreq, m_addr_valid, m_wdata_valid, derror, m_mode, drdata, and all counters SHALL be 0.
REQ-036 Reset asserted mid-transaction SHALL discard the transaction with no further serial output.

Structure
REQ-037 State encodings and the READ/WRITE mode constants SHALL reside in a shared bus package.
REQ-038 The single sub-module SHALL be serial_shifter: a parameterised LSB-first parallel-load/serial-out and serial-in/parallel-out register, used for both address and data.

Verification
REQ-039 Write case: accept at cycle T, daddr = 16'h8004, dwdata = 8'hA5, grant already high, m_ack in first ACK cycle. Required response:
- m_addr bits 0,0,1,0,...,1 on T+2..T+17
- m_wdata 1,0,1,0,0,1,0,1 on T+19..T+26
- DONE at T+27; dready = 1 and derror = 0 at T+28.
REQ-040 Read case: daddr = 16'h8004, slave returns 8'h3C with 2-cycle gaps between valid bits -> drdata = 8'h3C, derror = 0.
REQ-041 Ack timeout: m_ack never asserted -> ACK exits after 16 cycles, derror = 1, mbreq = 0, drdata unchanged.
REQ-042 Grant loss: mbgrant dropped at the 5th address bit -> m_addr_valid = 0 next cycle, derror = 1, DONE then IDLE.
REQ-043 Ignored request and reset: dvalid pulsed during WDATA is ignored; rstn = 0 in RDATA -> all outputs at reset values the next cycle, then a new write completes normally.

Source files
------------

// File: rtl/bus_master_port_pkg.sv
// Shared definitions for the serial bus master port: FSM encoding, mode
// constants and the "port owns the bus" state decode.
package bus_master_port_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ADDR,
        ACK,
        WDATA,
        RDATA,
        DONE
    } state_e;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    // mbreq is held for the whole span from arbitration to the last data bit.
    function automatic logic holds_bus(input state_e s);
        return (s == REQ) || (s == ADDR) || (s == ACK) || (s == WDATA) || (s == RDATA);
    endfunction

endpackage

// File: rtl/bus_master_port_serial_shifter.sv
// LSB-first shift register: parallel load with serial out, or serial in with
// parallel out. Bits enter at the MSB and leave from bit 0.
module serial_shifter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             ser_in,
    output logic             ser_out,
    output logic [WIDTH-1:0] par_out
);

    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;

    always_comb begin
        // NOTE: the hold value is assigned first so no path leaves shift_d unassigned (no latch).
        shift_d = shift_q;
        if (load) begin
            shift_d = load_data;
        end else if (shift_en) begin
            shift_d = {ser_in, shift_q[WIDTH-1:1]};
        end
    end

    // NOTE: the data register is reset too, so the serial lines never show stale bits after rstn.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign ser_out = shift_q[0];
    assign par_out = shift_q;

endmodule

// File: rtl/bus_master_port.sv
// Device-side request port that arbitrates for a serial bus, shifts out the
// address, waits for the slave's ack, then shifts write data out or read data in.
module bus_master_port
    import bus_master_port_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  dvalid,
    input  logic [ADDR_WIDTH-1:0] daddr,
    input  logic [DATA_WIDTH-1:0] dwdata,
    input  logic                  dmode,
    output logic                  dready,
    output logic [DATA_WIDTH-1:0] drdata,
    output logic                  derror,
    output logic                  mbreq,
    input  logic                  mbgrant,
    output logic                  m_mode,
    output logic                  m_addr,
    output logic                  m_addr_valid,
    output logic                  m_wdata,
    output logic                  m_wdata_valid,
    input  logic                  m_rdata,
    input  logic                  m_rdata_valid,
    input  logic                  m_ack
);

    localparam int AC_W = $clog2(ADDR_WIDTH);
    localparam int DC_W = $clog2(DATA_WIDTH);
    localparam int TC_W = $clog2(ACK_TIMEOUT);
    localparam logic [AC_W-1:0] ADDR_LAST = AC_W'(ADDR_WIDTH - 1);
    localparam logic [DC_W-1:0] DATA_LAST = DC_W'(DATA_WIDTH - 1);
    localparam logic [TC_W-1:0] ACK_LAST  = TC_W'(ACK_TIMEOUT - 1);

    state_e                state_q, state_d;
    logic [AC_W-1:0]       addr_cnt_q, addr_cnt_d;
    logic [DC_W-1:0]       data_cnt_q, data_cnt_d;
    logic [TC_W-1:0]       ack_cnt_q, ack_cnt_d;
    logic                  mode_q, mode_d;
    logic                  derror_q, derror_d;
    logic [DATA_WIDTH-1:0] drdata_q, drdata_d;
    logic                  dready_q, dready_d;
    logic                  mbreq_q, mbreq_d;
    logic                  addr_vld_q, addr_vld_d;
    logic                  wdata_vld_q, wdata_vld_d;

    logic                  addr_load, addr_shift, data_load, data_shift;
    logic [ADDR_WIDTH-1:0] addr_par_unused;
    logic [DATA_WIDTH-1:0] data_par;
    logic                  data_ser_unused;

    serial_shifter #(.WIDTH(ADDR_WIDTH)) u_addr_shifter (
        .clk       (clk),
        .rstn      (rstn),
        .load      (addr_load),
        .load_data (daddr),
        .shift_en  (addr_shift),
        .ser_in    (1'b0),
        .ser_out   (m_addr),
        .par_out   (addr_par_unused)
    );

    serial_shifter #(.WIDTH(DATA_WIDTH)) u_data_shifter (
        .clk       (clk),
        .rstn      (rstn),
        .load      (data_load),
        .load_data (dwdata),
        .shift_en  (data_shift),
        .ser_in    (m_rdata),
        .ser_out   (data_ser_unused),
        .par_out   (data_par)
    );

    always_comb begin
        state_d    = state_q;
        addr_cnt_d = addr_cnt_q;
        data_cnt_d = data_cnt_q;
        ack_cnt_d  = ack_cnt_q;
        mode_d     = mode_q;
        derror_d   = derror_q;
        drdata_d   = drdata_q;
        addr_load  = 1'b0;
        addr_shift = 1'b0;
        data_load  = 1'b0;
        data_shift = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (dvalid) begin
                    addr_load = 1'b1;
                    data_load = 1'b1;
                    mode_d    = dmode;
                    derror_d  = 1'b0;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (mbgrant) begin
                    addr_cnt_d = '0;
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                if (!mbgrant) begin
                    derror_d = 1'b1;
                    state_d  = DONE;
                end else begin
                    addr_shift = 1'b1;
                    if (addr_cnt_q == ADDR_LAST) begin
                        ack_cnt_d = '0;
                        state_d   = ACK;
                    end else begin
                        addr_cnt_d = addr_cnt_q + AC_W'(1);
                    end
                end
            end
            ACK: begin
                // Grant loss wins over a simultaneous ack: the bus is no longer ours.
                if (!mbgrant) begin
                    derror_d = 1'b1;
                    state_d  = DONE;
                end else if (m_ack) begin
                    data_cnt_d = '0;
                    state_d    = (mode_q == MODE_WRITE) ? WDATA : RDATA;
                end else if (ack_cnt_q == ACK_LAST) begin
                    derror_d = 1'b1;
                    state_d  = DONE;
                end else begin
                    ack_cnt_d = ack_cnt_q + TC_W'(1);
                end
            end
            WDATA: begin
                if (!mbgrant) begin
                    derror_d = 1'b1;
                    state_d  = DONE;
                end else begin
                    data_shift = 1'b1;
                    if (data_cnt_q == DATA_LAST) begin
                        state_d = DONE;
                    end else begin
                        data_cnt_d = data_cnt_q + DC_W'(1);
                    end
                end
            end
            RDATA: begin
                if (!mbgrant) begin
                    derror_d = 1'b1;
                    state_d  = DONE;
                end else if (m_rdata_valid) begin
                    data_shift = 1'b1;
                    if (data_cnt_q == DATA_LAST) begin
                        drdata_d = {m_rdata, data_par[DATA_WIDTH-1:1]};
                        state_d  = DONE;
                    end else begin
                        data_cnt_d = data_cnt_q + DC_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Bus-facing strobes are registered from the next state.
        dready_d    = (state_d == IDLE);
        mbreq_d     = holds_bus(state_d);
        addr_vld_d  = (state_d == ADDR);
        wdata_vld_d = (state_d == WDATA);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            addr_cnt_q  <= '0;
            data_cnt_q  <= '0;
            ack_cnt_q   <= '0;
            mode_q      <= 1'b0;
            derror_q    <= 1'b0;
            drdata_q    <= '0;
            dready_q    <= 1'b1;
            mbreq_q     <= 1'b0;
            addr_vld_q  <= 1'b0;
            wdata_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_cnt_q  <= addr_cnt_d;
            data_cnt_q  <= data_cnt_d;
            ack_cnt_q   <= ack_cnt_d;
            mode_q      <= mode_d;
            derror_q    <= derror_d;
            drdata_q    <= drdata_d;
            dready_q    <= dready_d;
            mbreq_q     <= mbreq_d;
            addr_vld_q  <= addr_vld_d;
            wdata_vld_q <= wdata_vld_d;
        end
    end

    assign dready        = dready_q;
    assign drdata        = drdata_q;
    assign derror        = derror_q;
    assign mbreq         = mbreq_q;
    assign m_mode        = mode_q;
    assign m_addr_valid  = addr_vld_q;
    assign m_wdata_valid = wdata_vld_q;
    assign m_wdata       = data_par[0];

endmodule

// File: tb/tb_bus_master_port.sv
// Scoreboard bench for bus_master_port: a slave/monitor process on the falling
// edge captures serial traffic and retires expected transactions on completion.
module tb_bus_master_port;
    import bus_master_port_pkg::*;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int TO = 16;

    typedef struct {
        logic          mode;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          exp_err;
        logic [DW-1:0] exp_rdata;
        int            exp_addr_bits;
        int            exp_wdata_bits;
        int            exp_ready_off;
        int            t_acc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          dvalid = 1'b0;
    logic [AW-1:0] daddr = '0;
    logic [DW-1:0] dwdata = '0;
    logic          dmode = 1'b0;
    logic          dready;
    logic [DW-1:0] drdata;
    logic          derror;
    logic          mbreq;
    logic          mbgrant;
    logic          m_mode;
    logic          m_addr, m_addr_valid;
    logic          m_wdata, m_wdata_valid;
    logic          m_rdata = 1'b0;
    logic          m_rdata_valid = 1'b0;
    logic          m_ack = 1'b0;

    // stimulus-owned slave controls
    logic          grant_en = 1'b1;
    logic          ack_en = 1'b1;
    int            drop_bit = 0;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] last_rdata = '0;

    // monitor-owned state
    logic          grant_cut = 1'b0;
    logic [AW-1:0] obs_addr = '0;
    logic [DW-1:0] obs_wdata = '0;
    int            addr_bits = 0;
    int            wdata_bits = 0;
    int            first_addr_cyc = -1;
    int            first_wdata_cyc = -1;
    logic          prev_ready = 1'b1;
    logic          acked = 1'b0;
    logic          rd_go = 1'b0;
    int            rd_sent = 0;
    int            gap = 0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    exp_t sb_q[$];

    assign mbgrant = grant_en & ~grant_cut;

    bus_master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACK_TIMEOUT(TO)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .dvalid        (dvalid),
        .daddr         (daddr),
        .dwdata        (dwdata),
        .dmode         (dmode),
        .dready        (dready),
        .drdata        (drdata),
        .derror        (derror),
        .mbreq         (mbreq),
        .mbgrant       (mbgrant),
        .m_mode        (m_mode),
        .m_addr        (m_addr),
        .m_addr_valid  (m_addr_valid),
        .m_wdata       (m_wdata),
        .m_wdata_valid (m_wdata_valid),
        .m_rdata       (m_rdata),
        .m_rdata_valid (m_rdata_valid),
        .m_ack         (m_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_monitor();
        obs_addr = '0;
        obs_wdata = '0;
        addr_bits = 0;
        wdata_bits = 0;
        first_addr_cyc = -1;
        first_wdata_cyc = -1;
        acked = 1'b0;
        rd_go = 1'b0;
        rd_sent = 0;
        gap = 0;
        grant_cut = 1'b0;
    endtask

    task automatic retire();
        exp_t e;
        logic [AW-1:0] mask;
        if (sb_q.size() == 0) begin
            check("unexpected_done", sb_q.size(), 1);
            return;
        end
        e = sb_q.pop_front();
        mask = (e.exp_addr_bits >= AW) ? '1 : AW'((1 << e.exp_addr_bits) - 1);
        check("derror", derror, e.exp_err);
        check("drdata", drdata, e.exp_rdata);
        check("mbreq_idle", mbreq, 0);
        check("addr_bits", addr_bits, e.exp_addr_bits);
        check("addr_val", obs_addr, e.addr & mask);
        check("addr_start", first_addr_cyc - e.t_acc, 2);
        check("wdata_bits", wdata_bits, e.exp_wdata_bits);
        if (e.exp_wdata_bits > 0) begin
            check("wdata_val", obs_wdata, e.wdata);
            check("wdata_start", first_wdata_cyc - e.t_acc, 2 + AW + 1);
        end
        check("ready_time", cyc - e.t_acc, e.exp_ready_off);
    endtask

    // Slave model and monitor, acting away from the DUT's active edge.
    always @(negedge clk) begin
        if (!rstn) begin
            clear_monitor();
            prev_ready = 1'b1;
            m_ack = 1'b0;
            m_rdata_valid = 1'b0;
            m_rdata = 1'b0;
        end else begin
            if (m_addr_valid && m_wdata_valid) check("valid_overlap", 1, 0);
            if (m_addr_valid) begin
                if (addr_bits == 0) first_addr_cyc = cyc;
                if (addr_bits < AW) obs_addr[addr_bits] = m_addr;
                addr_bits++;
                if (drop_bit != 0 && addr_bits == drop_bit) grant_cut = 1'b1;
            end
            if (m_wdata_valid) begin
                if (wdata_bits == 0) first_wdata_cyc = cyc;
                if (wdata_bits < DW) obs_wdata[wdata_bits] = m_wdata;
                wdata_bits++;
            end
            if (m_ack) begin
                m_ack = 1'b0;
                rd_go = (m_mode == MODE_READ);
            end else if (ack_en && !acked && addr_bits == AW && !m_addr_valid) begin
                m_ack = 1'b1;
                acked = 1'b1;
            end
            m_rdata_valid = 1'b0;
            if (rd_go && rd_sent < DW) begin
                if (gap == 0) begin
                    m_rdata_valid = 1'b1;
                    m_rdata = rd_data[rd_sent];
                    rd_sent++;
                    gap = 2;
                end else begin
                    gap--;
                end
            end
            if (dready && !prev_ready) begin
                retire();
                clear_monitor();
            end
            prev_ready = dready;
        end
    end

    task automatic start_txn(input logic mode, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                             input logic err, input int abits, input int ready_off);
        exp_t e;
        int n = 0;
        while (dready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_ready", dready, 1);
        dvalid = 1'b1;
        dmode  = mode;
        daddr  = addr;
        dwdata = wd;
        if (mode == MODE_READ && !err) last_rdata = rd_data;
        e.mode = mode;
        e.addr = addr;
        e.wdata = wd;
        e.exp_err = err;
        e.exp_rdata = last_rdata;
        e.exp_addr_bits = abits;
        e.exp_wdata_bits = (mode == MODE_WRITE && !err) ? DW : 0;
        e.exp_ready_off = ready_off;
        e.t_acc = cyc;
        sb_q.push_back(e);
        @(posedge clk); #1;
        dvalid = 1'b0;
        daddr  = AW'($urandom);
        dwdata = DW'($urandom);
        dmode  = 1'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("txn_done", sb_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dready"}, dready, 1);
        check({tag, "_mbreq"}, mbreq, 0);
        check({tag, "_avalid"}, m_addr_valid, 0);
        check({tag, "_wvalid"}, m_wdata_valid, 0);
        check({tag, "_derror"}, derror, 0);
        check({tag, "_mmode"}, m_mode, 0);
        check({tag, "_drdata"}, drdata, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int seen;
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // directed write: 0x8004 / 0xA5, grant high, ack in first ACK cycle
        start_txn(MODE_WRITE, 16'h8004, 8'hA5, 1'b0, AW, 28);
        wait_done();

        // directed read with 2-cycle gaps between valid bits
        rd_data = 8'h3C;
        start_txn(MODE_READ, 16'h8004, 8'h00, 1'b0, AW, 42);
        wait_done();

        // ack timeout: ACK occupies TO cycles, then DONE
        ack_en = 1'b0;
        rd_data = 8'hFF;
        start_txn(MODE_READ, 16'h1234, 8'h00, 1'b1, AW, 2 + AW + TO + 1);
        wait_done();
        ack_en = 1'b1;

        // grant lost on the 5th address bit
        drop_bit = 5;
        start_txn(MODE_WRITE, 16'hBEEF, 8'h77, 1'b1, 5, 2 + 5 + 1);
        wait_done();
        drop_bit = 0;

        // dvalid pulsed during WDATA must be ignored
        start_txn(MODE_WRITE, 16'h00F0, 8'h5A, 1'b0, AW, 28);
        n = 0;
        while (m_wdata_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_wdata", m_wdata_valid, 1);
        dvalid = 1'b1;
        dmode  = MODE_WRITE;
        daddr  = 16'hDEAD;
        dwdata = 8'h11;
        @(posedge clk); #1;
        dvalid = 1'b0;
        wait_done();
        repeat (40) @(posedge clk);
        #1;
        check("ignored_mbreq", mbreq, 0);
        check("ignored_dready", dready, 1);

        // reset asserted in RDATA
        rd_data = 8'h5A;
        start_txn(MODE_READ, 16'h4321, 8'h00, 1'b0, AW, 42);
        n = 0;
        while (rd_sent < 2 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("rd_progress", (rd_sent >= 2), 1);
        rstn = 1'b0;
        sb_q.delete();
        last_rdata = '0;
        @(posedge clk); #1;
        check_reset_outputs("midrst");
        rstn = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (m_addr_valid || m_wdata_valid || mbreq) seen++;
        end
        check("no_serial_after_rst", seen, 0);

        // a fresh write after reset completes normally
        start_txn(MODE_WRITE, 16'h5555, 8'h96, 1'b0, AW, 28);
        wait_done();

        // a few mixed transactions with random payloads
        for (int i = 0; i < 4; i++) begin
            ra = AW'($urandom);
            rd = DW'($urandom);
            if (i[0]) begin
                rd_data = rd;
                start_txn(MODE_READ, ra, 8'h00, 1'b0, AW, 42);
            end else begin
                start_txn(MODE_WRITE, ra, rd, 1'b0, AW, 28);
            end
            wait_done();
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
